timer_counter_cmp: RTL and testbench

//  Parametrised free-running timer: prescaled counter with load/clear, NUM_CMP

---
 rtl/timer_counter_cmp.sv | 72 +++++++
 tb/tb_timer_counter_cmp.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/timer_counter_cmp.sv
// timer_counter_cmp: prescaled timer with load/clear, compare channels, sticky flags, debug halt; define TIMER_AUTO_CLR_EN for periodic mode (channel 0 match wraps count)
module timer_counter_cmp #(
    parameter int CNT_WIDTH = 64,
    parameter int DIV_WIDTH = 8,
    parameter int NUM_CMP   = 2
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst,
    input  logic                         timer_en,
    input  logic                         div_en,
    input  logic [DIV_WIDTH-1:0]         div_val,
    input  logic                         count_clr,
    input  logic                         count_ld,
    input  logic [CNT_WIDTH-1:0]         count_ld_val,
    input  logic [NUM_CMP*CNT_WIDTH-1:0] cmp_val,
    input  logic [NUM_CMP-1:0]           cmp_en,
    input  logic [NUM_CMP-1:0]           int_en,
    input  logic [NUM_CMP-1:0]           int_clr,
    input  logic                         ovf_clr,
    input  logic                         halt_req,
    output logic                         halt_ack,
    output logic [CNT_WIDTH-1:0]         count,
    output logic [NUM_CMP-1:0]           int_st,
    output logic                         ovf_st,
    output logic [NUM_CMP-1:0]           irq
);
    logic [DIV_WIDTH-1:0] div_cnt;
    logic [NUM_CMP-1:0]   match;
    logic                 run;
    logic                 tick;
    logic                 wrap;
    logic                 ovf_set;
    assign run  = timer_en & ~halt_ack;
    assign tick = run & (~div_en | (div_cnt >= div_val));
`ifdef TIMER_AUTO_CLR_EN
    assign wrap = tick & match[0];
`else
    assign wrap = 1'b0;
`endif
    assign ovf_set = tick & ~count_clr & ~count_ld & ~wrap & (&count);
    assign irq     = int_st & int_en;
    // per-channel compare against the registered count
    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_CMP; i++)
            match[i] = cmp_en[i] & (count == cmp_val[i*CNT_WIDTH +: CNT_WIDTH]);
    end
    // prescaler: restarts whenever idle, bypassed, cleared or on its own tick
    always_ff @(posedge sys_clk) begin
        if (sys_rst)
            div_cnt <= '0;
        else
            div_cnt <= (~run | ~div_en | count_clr | tick) ? '0 : div_cnt + DIV_WIDTH'(1);
    end
    // counter, halt handshake and sticky flags (set beats clear)
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            count    <= '0;
            halt_ack <= 1'b0;
            int_st   <= '0;
            ovf_st   <= 1'b0;
        end else begin
            count    <= count_clr ? '0 :
                        count_ld  ? count_ld_val :
                        wrap      ? '0 :
                        tick      ? count + CNT_WIDTH'(1) : count;
            halt_ack <= halt_req;
            int_st   <= match | (int_st & ~int_clr);
            ovf_st   <= ovf_set | (ovf_st & ~ovf_clr);
        end
    end
endmodule

// File: tb/tb_timer_counter_cmp.sv
// tb_timer_counter_cmp: directed self-checking bench for timer_counter_cmp (8-bit counter instance)
module tb_timer_counter_cmp;
    localparam int W = 8;
    localparam int D = 8;
    localparam int N = 2;
    logic         sys_clk = 1'b0;
    logic         sys_rst;
    logic         timer_en;
    logic         div_en;
    logic [D-1:0] div_val;
    logic         count_clr;
    logic         count_ld;
    logic [W-1:0] count_ld_val;
    logic [N*W-1:0] cmp_val;
    logic [N-1:0] cmp_en;
    logic [N-1:0] int_en;
    logic [N-1:0] int_clr;
    logic         ovf_clr;
    logic         halt_req;
    logic         halt_ack;
    logic [W-1:0] count;
    logic [N-1:0] int_st;
    logic         ovf_st;
    logic [N-1:0] irq;
    int n_cmp = 0;
    int n_bad = 0;

    timer_counter_cmp #(.CNT_WIDTH(W), .DIV_WIDTH(D), .NUM_CMP(N)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .timer_en(timer_en), .div_en(div_en),
        .div_val(div_val), .count_clr(count_clr), .count_ld(count_ld),
        .count_ld_val(count_ld_val), .cmp_val(cmp_val), .cmp_en(cmp_en),
        .int_en(int_en), .int_clr(int_clr), .ovf_clr(ovf_clr), .halt_req(halt_req),
        .halt_ack(halt_ack), .count(count), .int_st(int_st), .ovf_st(ovf_st), .irq(irq)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    initial begin
        timer_en = 1'b1; div_en = 1'b0; div_val = '0; count_clr = 1'b0;
        count_ld = 1'b1; count_ld_val = 8'd55; cmp_val = '0; cmp_en = '0;
        int_en = '0; int_clr = '0; ovf_clr = 1'b0; halt_req = 1'b1; sys_rst = 1'b1;
        step(2);
        chk("rst_count", count, 0);
        chk("rst_halt_ack", halt_ack, 0);
        chk("rst_int_st", int_st, 0);
        chk("rst_ovf", ovf_st, 0);
        chk("rst_irq", irq, 0);
        count_ld = 1'b0; halt_req = 1'b0; sys_rst = 1'b0;
        // free-running, tick every cycle
        step(10);
        chk("t1_count", count, 10);
        chk("t1_int_st", int_st, 0);
        chk("t1_ovf", ovf_st, 0);
        // prescaler /4, then lower div_val mid-period
        count_clr = 1'b1; div_en = 1'b1; div_val = 8'd3;
        step(1);
        count_clr = 1'b0;
        chk("t2_clr", count, 0);
        step(12);
        chk("t2_div4", count, 3);
        step(2);
        chk("t2_mid", count, 3);
        div_val = 8'd0;
        step(1);
        chk("t2_lower", count, 4);
        step(1);
        chk("t2_every1", count, 5);
        step(1);
        chk("t2_every2", count, 6);
        div_en = 1'b0;
        // overflow wrap and set-beats-clear
        count_ld = 1'b1; count_ld_val = 8'hFE;
        step(1);
        count_ld = 1'b0;
        chk("t3_load", count, 8'hFE);
        chk("t3_ld_noovf", ovf_st, 0);
        step(2);
        chk("t3_wrap", count, 0);
        chk("t3_ovf", ovf_st, 1);
        count_ld = 1'b1; count_ld_val = 8'hFF; ovf_clr = 1'b1;
        step(1);
        count_ld = 1'b0;
        chk("t3_ovf_clr", ovf_st, 0);
        chk("t3_load_ff", count, 8'hFF);
        step(1);
        ovf_clr = 1'b0;
        chk("t3_wrap2", count, 0);
        chk("t3_set_wins", ovf_st, 1);
        // compare channel 1, channel 0 disabled while matching 0
        count_clr = 1'b1; cmp_val = {8'd5, 8'd0}; cmp_en = 2'b10; int_en = 2'b10;
        step(1);
        count_clr = 1'b0;
        step(5);
        chk("t4_count5", count, 5);
        chk("t4_pre", int_st, 0);
        step(1);
        chk("t4_int_st", int_st, 2'b10);
        chk("t4_irq", irq, 2'b10);
        step(1);
        chk("t4_count7", count, 7);
        int_clr = 2'b10;
        step(1);
        int_clr = '0;
        chk("t4_clr", int_st, 0);
        chk("t4_irq_clr", irq, 0);
        cmp_en = '0;
        // debug halt
        count_clr = 1'b1;
        step(1);
        count_clr = 1'b0;
        step(20);
        chk("t5_count20", count, 20);
        halt_req = 1'b1;
        step(1);
        chk("t5_ack", halt_ack, 1);
        chk("t5_count21", count, 21);
        step(3);
        chk("t5_frozen", count, 21);
        count_ld = 1'b1; count_ld_val = 8'd100;
        step(1);
        count_ld = 1'b0;
        chk("t5_ld", count, 100);
        step(2);
        chk("t5_hold", count, 100);
        halt_req = 1'b0;
        step(1);
        chk("t5_ack_off", halt_ack, 0);
        chk("t5_still", count, 100);
        step(1);
        chk("t5_resume", count, 101);
        // channel 0 compare / periodic mode
        count_clr = 1'b1; ovf_clr = 1'b1; int_clr = 2'b11;
        cmp_val = {8'hAA, 8'd4}; cmp_en = 2'b01;
        step(1);
        count_clr = 1'b0; ovf_clr = 1'b0; int_clr = '0;
        chk("t6_clr", count, 0);
        step(4);
        chk("t6_count4", count, 4);
        chk("t6_pre", int_st, 0);
        step(1);
`ifdef TIMER_AUTO_CLR_EN
        chk("t6_wrap", count, 0);
`else
        chk("t6_wrap", count, 5);
`endif
        chk("t6_int0", int_st, 2'b01);
        chk("t6_ovf", ovf_st, 0);
        step(1);
`ifdef TIMER_AUTO_CLR_EN
        chk("t6_next", count, 1);
`else
        chk("t6_next", count, 6);
`endif
        // timer_en low holds count
        timer_en = 1'b0;
        step(3);
`ifdef TIMER_AUTO_CLR_EN
        chk("t7_hold", count, 1);
`else
        chk("t7_hold", count, 6);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
